// File: rtl/mouse_cfg_ctl.sv
// Drives the H/V limit and cursor-position load strobes into the mouse controller after reset, then serves recenter/warp requests.
// Registered outputs, one strobe per sequence step, GAP idle cycles between strobes; one-deep pending request; warp via MOUSE_WARP_EN.
module mouse_cfg_ctl #(
    parameter logic [11:0] H_MAX = 12'd1279,
    parameter logic [11:0] V_MAX = 12'd719,
    parameter int unsigned GAP   = 4
) (
    input  logic        clk100MHz,
    input  logic        rst_n,
    input  logic        recenter_req,
`ifdef MOUSE_WARP_EN
    input  logic        warp_req,
    input  logic [11:0] warp_x,
    input  logic [11:0] warp_y,
`endif
    output logic [11:0] value,
    output logic        setmax_x,
    output logic        setmax_y,
    output logic        setx,
    output logic        sety,
    output logic        busy,
    output logic        cfg_done
);

    typedef enum logic [2:0] {S_MAXX, S_MAXY, S_X, S_Y, S_GAP, S_READY} state_t;

    localparam logic [11:0] H_CTR  = H_MAX >> 1;
    localparam logic [11:0] V_CTR  = V_MAX >> 1;
    localparam logic [3:0]  GAP_LD = 4'(GAP);

    state_t      state_q, state_d, ret_q, ret_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        pend_q, pend_d;
    logic        req_any;

    logic [11:0] value_q, value_d;
    logic        setmax_x_q, setmax_x_d, setmax_y_q, setmax_y_d;
    logic        setx_q, setx_d, sety_q, sety_d;
    logic        busy_q, busy_d, cfg_done_q, cfg_done_d;
    logic [11:0] x_tgt, y_tgt;

`ifdef MOUSE_WARP_EN
    logic        pend_warp_q, pend_warp_d;
    logic [11:0] pend_x_q, pend_x_d, pend_y_q, pend_y_d;
    logic [11:0] act_x_q, act_x_d, act_y_q, act_y_d;
    logic [11:0] req_x, req_y;

    assign req_any = recenter_req | warp_req;
    // Warp wins over a simultaneous recenter; targets clamp to the screen limits.
    assign req_x = warp_req ? ((warp_x > H_MAX) ? H_MAX : warp_x) : H_CTR;
    assign req_y = warp_req ? ((warp_y > V_MAX) ? V_MAX : warp_y) : V_CTR;
    // The init sequence always centres; later sequences use the latched targets.
    assign x_tgt = cfg_done_q ? act_x_q : H_CTR;
    assign y_tgt = cfg_done_q ? act_y_q : V_CTR;
`else
    assign req_any = recenter_req;
    assign x_tgt   = H_CTR;
    assign y_tgt   = V_CTR;
`endif

    always_ff @(posedge clk100MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_MAXX;
            ret_q       <= S_MAXY;
            cnt_q       <= 4'd0;
            pend_q      <= 1'b0;
`ifdef MOUSE_WARP_EN
            pend_warp_q <= 1'b0;
            pend_x_q    <= 12'd0;
            pend_y_q    <= 12'd0;
            act_x_q     <= 12'd0;
            act_y_q     <= 12'd0;
`endif
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
`ifdef MOUSE_WARP_EN
            pend_warp_q <= pend_warp_d;
            pend_x_q    <= pend_x_d;
            pend_y_q    <= pend_y_d;
            act_x_q     <= act_x_d;
            act_y_q     <= act_y_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        ret_d       = ret_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
`ifdef MOUSE_WARP_EN
        pend_warp_d = pend_warp_q;
        pend_x_d    = pend_x_q;
        pend_y_d    = pend_y_q;
        act_x_d     = act_x_q;
        act_y_d     = act_y_q;
`endif
        case (state_q)
            S_MAXX: begin state_d = S_GAP; cnt_d = GAP_LD; ret_d = S_MAXY;  end
            S_MAXY: begin state_d = S_GAP; cnt_d = GAP_LD; ret_d = S_X;     end
            S_X:    begin state_d = S_GAP; cnt_d = GAP_LD; ret_d = S_Y;     end
            S_Y:    begin state_d = S_GAP; cnt_d = GAP_LD; ret_d = S_READY; end
            S_GAP: begin
                if (cnt_q <= 4'd1) state_d = ret_q;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_READY: begin
                // A pending request takes this slot; a new one arriving now is dropped.
                if (pend_q) begin
                    state_d = S_X;
                    pend_d  = 1'b0;
`ifdef MOUSE_WARP_EN
                    act_x_d = pend_x_q;
                    act_y_d = pend_y_q;
`endif
                end else if (req_any) begin
                    state_d = S_X;
`ifdef MOUSE_WARP_EN
                    act_x_d = req_x;
                    act_y_d = req_y;
`endif
                end
            end
            default: state_d = S_MAXX;
        endcase

        if (state_q != S_READY && req_any) begin
            if (!pend_q) begin
                pend_d      = 1'b1;
`ifdef MOUSE_WARP_EN
                pend_warp_d = warp_req;
                pend_x_d    = req_x;
                pend_y_d    = req_y;
            end else if (!pend_warp_q && warp_req) begin
                pend_warp_d = 1'b1;
                pend_x_d    = req_x;
                pend_y_d    = req_y;
`endif
            end
        end
    end

    always_comb begin
        value_d    = value_q;
        setmax_x_d = 1'b0;
        setmax_y_d = 1'b0;
        setx_d     = 1'b0;
        sety_d     = 1'b0;
        busy_d     = (state_q != S_READY);
        cfg_done_d = cfg_done_q | (state_q == S_READY);
        case (state_q)
            S_MAXX:  begin setmax_x_d = 1'b1; value_d = H_MAX; end
            S_MAXY:  begin setmax_y_d = 1'b1; value_d = V_MAX; end
            S_X:     begin setx_d     = 1'b1; value_d = x_tgt; end
            S_Y:     begin sety_d     = 1'b1; value_d = y_tgt; end
            default: ;
        endcase
    end

    always_ff @(posedge clk100MHz or negedge rst_n) begin
        if (!rst_n) begin
            value_q    <= 12'd0;
            setmax_x_q <= 1'b0;
            setmax_y_q <= 1'b0;
            setx_q     <= 1'b0;
            sety_q     <= 1'b0;
            busy_q     <= 1'b1;
            cfg_done_q <= 1'b0;
        end else begin
            value_q    <= value_d;
            setmax_x_q <= setmax_x_d;
            setmax_y_q <= setmax_y_d;
            setx_q     <= setx_d;
            sety_q     <= sety_d;
            busy_q     <= busy_d;
            cfg_done_q <= cfg_done_d;
        end
    end

    assign value    = value_q;
    assign setmax_x = setmax_x_q;
    assign setmax_y = setmax_y_q;
    assign setx     = setx_q;
    assign sety     = sety_q;
    assign busy     = busy_q;
    assign cfg_done = cfg_done_q;

endmodule
